neopixel_pattern_gen: RTL

Parametrised colour-pattern source for the neopixel_tx_fsm transmitter. It holds a writable palette of NCOLORS 24-bit colours and maps it cyclically onto an NPIX-pixel strip. It emits pixel messages followed by RESET_SLOTS latch/reset messages per frame. The pattern rotates forward or backward one palette step every TICK_DIV input ticks, applied only at frame boundaries so no frame is torn.

---
 rtl/neopixel_pattern_gen_if.sv | 25 ++
 rtl/neopixel_pattern_gen.sv | 99 +++++++++
 2 files changed

// File: rtl/neopixel_pattern_gen_if.sv
// Control/data bundle between a pattern source and its neopixel transmitter side.
// master drives the controls and transmitter pulses; slave is the pattern generator.
interface neopixel_pattern_gen_if;
   logic        tick;
   logic        rd_next;
   logic        dir;
   logic        pause;
   logic        load_en;
   logic [7:0]  load_idx;
   logic [23:0] load_color;
   logic [23:0] pix_data;
   logic        msg_typ;
   logic        frame_done;
   logic [15:0] step_count;

   modport master (
      output tick, rd_next, dir, pause, load_en, load_idx, load_color,
      input  pix_data, msg_typ, frame_done, step_count
   );

   modport slave (
      input  tick, rd_next, dir, pause, load_en, load_idx, load_color,
      output pix_data, msg_typ, frame_done, step_count
   );
endinterface

// File: rtl/neopixel_pattern_gen.sv
// Rotating palette pattern source: NPIX pixel messages then RESET_SLOTS reset messages per frame.
// Zero-latency outputs from registers; two rd_next pulses consume one message; rotation applied only at frame wrap.
module neopixel_pattern_gen #(
   parameter int NPIX        = 18,
   parameter int NCOLORS     = 6,
   parameter int RESET_SLOTS = 14,
   parameter int TICK_DIV    = 512,
   parameter logic [24*NCOLORS-1:0] PALETTE_INIT =
      {24'h330033, 24'h000066, 24'h003333, 24'h006600, 24'h333300, 24'h660000}
) (
   input logic clk,
   input logic rst,
   neopixel_pattern_gen_if.slave bus
);
   localparam int SLOTS = NPIX + RESET_SLOTS;
   localparam int PW    = $clog2(SLOTS);
   localparam int CW    = (NCOLORS > 1) ? $clog2(NCOLORS) : 1;
   localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [23:0]   palette [NCOLORS];
   logic [PW-1:0] pos;
   logic          half;
   logic [CW-1:0] offset;
   logic [CW-1:0] col_idx;
   logic [CW-1:0] next_off;
   logic [TW-1:0] cnt;
   logic          step_pend;
   logic          frame_done;
   logic [15:0]   step_count;
   logic          period_done;
   logic          wrap;
   logic          apply;

   always_comb begin
      period_done = bus.tick && !bus.pause && (cnt == TW'(TICK_DIV - 1));
      wrap        = bus.rd_next && half && (pos == PW'(SLOTS - 1));
      apply       = wrap && step_pend && !bus.pause;
      next_off    = offset;
      if (apply) begin
         if (bus.dir)
            next_off = (offset == '0) ? CW'(NCOLORS - 1) : offset - CW'(1);
         else
            next_off = (offset == CW'(NCOLORS - 1)) ? '0 : offset + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos        <= '0;
         half       <= 1'b0;
         offset     <= '0;
         col_idx    <= '0;
         cnt        <= '0;
         step_pend  <= 1'b0;
         frame_done <= 1'b0;
         step_count <= '0;
         for (int i = 0; i < NCOLORS; i++)
            palette[i] <= PALETTE_INIT[i*24 +: 24];
      end else begin
         frame_done <= 1'b0;

         for (int i = 0; i < NCOLORS; i++)
            if (bus.load_en && (32'(bus.load_idx) == i))
               palette[i] <= bus.load_color;

         if (bus.tick && !bus.pause)
            cnt <= (cnt == TW'(TICK_DIV - 1)) ? '0 : cnt + TW'(1);

         // A period completing on the wrap cycle re-arms after the old step is consumed
         if (period_done)
            step_pend <= 1'b1;
         else if (apply)
            step_pend <= 1'b0;

         if (bus.rd_next) begin
            half <= ~half;
            if (half) begin
               if (wrap) begin
                  pos        <= '0;
                  frame_done <= 1'b1;
                  offset     <= next_off;
                  col_idx    <= next_off;
                  if (apply)
                     step_count <= step_count + 16'd1;
               end else begin
                  pos <= pos + PW'(1);
                  if (32'(pos) < NPIX - 1)
                     col_idx <= (col_idx == CW'(NCOLORS - 1)) ? '0 : col_idx + CW'(1);
               end
            end
         end
      end
   end

   assign bus.pix_data   = palette[col_idx];
   assign bus.msg_typ    = (32'(pos) < NPIX);
   assign bus.frame_done = frame_done;
   assign bus.step_count = step_count;
endmodule
